// File: rtl/gpu_pkg.sv
// Shared types, opcodes and default field widths for the GPU command decoder.
package gpu_pkg;

  localparam int unsigned DefWidthBits   = 10;
  localparam int unsigned DefHeightBits  = 9;
  localparam int unsigned DefChannelBits = 8;

  localparam logic [3:0] OP_RESET   = 4'b0000;
  localparam logic [3:0] OP_SET_XY1 = 4'b0001;
  localparam logic [3:0] OP_SET_XY2 = 4'b0010;
  localparam logic [3:0] OP_SET_RAD = 4'b0011;
  localparam logic [3:0] OP_LINE    = 4'b0100;
  localparam logic [3:0] OP_RECT    = 4'b0101;
  localparam logic [3:0] OP_CIRCLE  = 4'b0110;
  localparam logic [3:0] OP_ARC     = 4'b0111;
  localparam logic [3:0] OP_FILL    = 4'b1000;

  typedef struct packed {
    logic [3:0]                opcode;
    logic [DefWidthBits-1:0]   x1;
    logic [DefHeightBits-1:0]  y1;
    logic [DefWidthBits-1:0]   x2;
    logic [DefHeightBits-1:0]  y2;
    logic [DefWidthBits-1:0]   rad;
    logic [2:0]                oct;
    logic [DefChannelBits-1:0] r;
    logic [DefChannelBits-1:0] g;
    logic [DefChannelBits-1:0] b;
  } instr_t;

  function automatic logic is_draw_op(input logic [3:0] op);
    return (op >= OP_LINE) && (op <= OP_FILL);
  endfunction

  function automatic logic is_illegal_op(input logic [3:0] op);
    return op > OP_FILL;
  endfunction

endpackage

// File: rtl/gpu_instr_fifo.sv
// Power-of-two instruction queue with synchronous flush; flush and reset beat push/pop.
module gpu_instr_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic                       clk,
  input  logic                       n_rst,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic [Width-1:0]           data_i,
  input  logic                       pop_i,
  output logic [Width-1:0]           data_o,
  output logic                       valid_o,
  output logic                       full_o,
  output logic [$clog2(Depth+1)-1:0] count_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CntW'(Depth));
  assign valid_o = (count_q != '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && valid_o;
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Pointers wrap for free since Depth is a power of two.
      if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      count_d = count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (n_rst && do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/gpu_command_decoder.sv
// Decodes command words into shadow coordinate state and queued draw instructions.
module gpu_command_decoder
  import gpu_pkg::*;
#(
  parameter int unsigned WIDTH_BITS   = DefWidthBits,
  parameter int unsigned HEIGHT_BITS  = DefHeightBits,
  parameter int unsigned CHANNEL_BITS = DefChannelBits,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                            clk,
  input  logic                            n_rst,
  input  logic                            cmd_valid_i,
  output logic                            cmd_ready_o,
  input  logic [3:0]                      opcode_i,
  input  logic [27:0]                     parameters_i,
  output logic                            instr_valid_o,
  input  logic                            instr_ready_i,
  output instr_t                          instr_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count_o,
  output logic                            illegal_o,
  input  logic                            clear_err_i
);

  if (WIDTH_BITS + HEIGHT_BITS > 28 || 3 * CHANNEL_BITS > 25) begin : g_bad_widths
    $error("gpu_command_decoder: coordinate or colour fields exceed the 28-bit payload");
  end
  if (WIDTH_BITS > DefWidthBits || HEIGHT_BITS > DefHeightBits ||
      CHANNEL_BITS > DefChannelBits) begin : g_bad_instr
    $error("gpu_command_decoder: field widths exceed instr_t");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("gpu_command_decoder: FIFO_DEPTH must be a power of two, at least 2");
  end

  localparam int unsigned W = WIDTH_BITS;
  localparam int unsigned H = HEIGHT_BITS;
  localparam int unsigned C = CHANNEL_BITS;

  logic [W-1:0] x1_q, x1_d, x2_q, x2_d, rad_q, rad_d;
  logic [H-1:0] y1_q, y1_d, y2_q, y2_d;
  logic         illegal_q, illegal_d;
  logic         fifo_full, fifo_valid, accept, push, flush;
  logic [$bits(instr_t)-1:0] fifo_dout;
  instr_t       entry;
  logic         unused_payload;

  assign unused_payload = ^parameters_i;

  // Reset holds the handshake outputs at their empty-queue values.
  assign cmd_ready_o   = is_draw_op(opcode_i) ? (!fifo_full || !n_rst) : 1'b1;
  assign instr_valid_o = fifo_valid && n_rst;
  assign accept        = cmd_valid_i && cmd_ready_o;
  assign push          = accept && is_draw_op(opcode_i);
  assign flush         = accept && (opcode_i == OP_RESET);
  assign illegal_o     = illegal_q;
  assign instr_o       = instr_t'(fifo_dout);

  always_comb begin
    x1_d  = x1_q;
    y1_d  = y1_q;
    x2_d  = x2_q;
    y2_d  = y2_q;
    rad_d = rad_q;
    if (accept) begin
      case (opcode_i)
        OP_RESET: begin
          x1_d  = '0;
          y1_d  = '0;
          x2_d  = '0;
          y2_d  = '0;
          rad_d = '0;
        end
        OP_SET_XY1: begin
          x1_d = parameters_i[W-1:0];
          y1_d = parameters_i[W+H-1:W];
        end
        OP_SET_XY2: begin
          x2_d = parameters_i[W-1:0];
          y2_d = parameters_i[W+H-1:W];
        end
        OP_SET_RAD: rad_d = parameters_i[W-1:0];
        default: ;
      endcase
    end
    // An illegal accept wins over a simultaneous clear.
    if (accept && is_illegal_op(opcode_i)) illegal_d = 1'b1;
    else if (clear_err_i)                  illegal_d = 1'b0;
    else                                   illegal_d = illegal_q;
  end

  always_comb begin
    entry        = '0;
    entry.opcode = opcode_i;
    entry.x1     = DefWidthBits'(x1_q);
    entry.y1     = DefHeightBits'(y1_q);
    entry.x2     = DefWidthBits'(x2_q);
    entry.y2     = DefHeightBits'(y2_q);
    entry.rad    = DefWidthBits'(rad_q);
    entry.oct    = (opcode_i == OP_ARC) ? parameters_i[27:25] : 3'd0;
    entry.b      = DefChannelBits'(parameters_i[C-1:0]);
    entry.g      = DefChannelBits'(parameters_i[2*C-1:C]);
    entry.r      = DefChannelBits'(parameters_i[3*C-1:2*C]);
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      x1_q      <= '0;
      y1_q      <= '0;
      x2_q      <= '0;
      y2_q      <= '0;
      rad_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      x1_q      <= x1_d;
      y1_q      <= y1_d;
      x2_q      <= x2_d;
      y2_q      <= y2_d;
      rad_q     <= rad_d;
      illegal_q <= illegal_d;
    end
  end

  gpu_instr_fifo #(
    .Width ($bits(instr_t)),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .n_rst   (n_rst),
    .flush_i (flush),
    .push_i  (push),
    .data_i  (entry),
    .pop_i   (instr_ready_i && instr_valid_o),
    .data_o  (fifo_dout),
    .valid_o (fifo_valid),
    .full_o  (fifo_full),
    .count_o (fifo_count_o)
  );

endmodule

// File: tb/tb_gpu_command_decoder.sv
// Scoreboard bench: stimulus queues hand-computed entries, a monitor checks each popped head.
module tb_gpu_command_decoder;
  import gpu_pkg::*;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [3:0]  opcode = 4'd0;
  logic [27:0] params = 28'd0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  instr_t      instr;
  logic [2:0]  count;
  logic        illegal;
  logic        clear_err = 1'b0;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  instr_t      sb[$];

  always #5 clk = ~clk;

  gpu_command_decoder dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .cmd_valid_i   (cmd_valid),
    .cmd_ready_o   (cmd_ready),
    .opcode_i      (opcode),
    .parameters_i  (params),
    .instr_valid_o (instr_valid),
    .instr_ready_i (instr_ready),
    .instr_o       (instr),
    .fifo_count_o  (count),
    .illegal_o     (illegal),
    .clear_err_i   (clear_err)
  );

  function automatic instr_t mk(input logic [3:0] op, input logic [9:0] x1, input logic [8:0] y1,
                                input logic [9:0] x2, input logic [8:0] y2, input logic [9:0] rad,
                                input logic [2:0] oct, input logic [7:0] r, input logic [7:0] g,
                                input logic [7:0] b);
    return '{opcode: op, x1: x1, y1: y1, x2: x2, y2: y2, rad: rad, oct: oct, r: r, g: g, b: b};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Present a command until accepted, bounded by a cycle budget.
  task automatic issue(input logic [3:0] op, input logic [27:0] p);
    int unsigned waited = 0;
    opcode    = op;
    params    = p;
    cmd_valid = 1'b1;
    @(negedge clk);
    while (!cmd_ready && waited < 20) begin
      waited++;
      @(negedge clk);
    end
    if (!cmd_ready) begin
      n_checks++;
      n_errors++;
      $display("FAIL issue_timeout: op %h never accepted", op);
    end
    sync();
    cmd_valid = 1'b0;
  endtask

  task automatic pop_one();
    instr_ready = 1'b1;
    sync();
    instr_ready = 1'b0;
  endtask

  always @(negedge clk) begin
    if (n_rst && instr_valid && instr_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_entry: got %h expected none", instr);
      end else begin
        check("head_entry", 128'(instr), 128'(sb.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    opcode = OP_LINE;
    sync();
    sync();
    @(negedge clk);
    check("rst_count", 128'(count), 128'd0);
    check("rst_valid", 128'(instr_valid), 128'd0);
    check("rst_illegal", 128'(illegal), 128'd0);
    check("rst_ready", 128'(cmd_ready), 128'd1);
    sync();
    n_rst = 1'b1;

    // Basic line with both coordinate pairs set.
    issue(OP_SET_XY1, {9'd0, 9'd100, 10'd200});
    issue(OP_SET_XY2, {9'd0, 9'd5, 10'd7});
    sb.push_back(mk(OP_LINE, 10'd200, 9'd100, 10'd7, 9'd5, 10'd0, 3'd0, 8'hFF, 8'h80, 8'h01));
    issue(OP_LINE, 28'h0FF8001);
    @(negedge clk);
    check("line_latency_valid", 128'(instr_valid), 128'd1);
    check("line_count", 128'(count), 128'd1);
    sync();
    pop_one();
    @(negedge clk);
    check("drained_count", 128'(count), 128'd0);
    check("drained_valid", 128'(instr_valid), 128'd0);
    sync();

    // Octant only carried by arc.
    issue(OP_SET_RAD, 28'd33);
    sb.push_back(mk(OP_ARC, 10'd200, 9'd100, 10'd7, 9'd5, 10'd33, 3'd5, 8'h12, 8'h34, 8'h56));
    issue(OP_ARC, {3'd5, 1'b0, 24'h123456});
    sb.push_back(mk(OP_CIRCLE, 10'd200, 9'd100, 10'd7, 9'd5, 10'd33, 3'd0, 8'hAB, 8'hCD, 8'hEF));
    issue(OP_CIRCLE, {3'd7, 1'b0, 24'hABCDEF});
    @(negedge clk);
    check("arc_circle_count", 128'(count), 128'd2);
    sync();
    pop_one();
    pop_one();

    // Fill the queue, stall the fifth draw, let a set_radius through.
    for (int i = 1; i <= 4; i++) begin
      sb.push_back(mk(OP_RECT, 10'd200, 9'd100, 10'd7, 9'd5, 10'd33, 3'd0, 8'h00, 8'h00, 8'(i)));
      issue(OP_RECT, 28'(i));
    end
    @(negedge clk);
    check("full_count", 128'(count), 128'd4);
    sync();
    opcode = OP_RECT; params = 28'd5; cmd_valid = 1'b1;
    @(negedge clk);
    check("draw_stall", 128'(cmd_ready), 128'd0);
    sync();
    opcode = OP_SET_RAD; params = 28'd44;
    @(negedge clk);
    check("setrad_during_stall", 128'(cmd_ready), 128'd1);
    sync();
    opcode = OP_RECT; params = 28'd5;
    @(negedge clk);
    check("draw_still_stalled", 128'(cmd_ready), 128'd0);
    check("full_count_hold", 128'(count), 128'd4);
    sync();
    instr_ready = 1'b1;
    @(negedge clk);
    check("stall_during_pop", 128'(cmd_ready), 128'd0);
    sync();
    instr_ready = 1'b0;
    sb.push_back(mk(OP_RECT, 10'd200, 9'd100, 10'd7, 9'd5, 10'd44, 3'd0, 8'h00, 8'h00, 8'h05));
    @(negedge clk);
    check("ready_after_pop", 128'(cmd_ready), 128'd1);
    check("count_after_pop", 128'(count), 128'd3);
    sync();
    cmd_valid = 1'b0;
    @(negedge clk);
    check("refilled_count", 128'(count), 128'd4);
    sync();

    // Simultaneous push and pop keeps the count.
    pop_one();
    sb.push_back(mk(OP_FILL, 10'd200, 9'd100, 10'd7, 9'd5, 10'd44, 3'd0, 8'h0A, 8'h0B, 8'h0C));
    opcode = OP_FILL; params = 28'h00A0B0C; cmd_valid = 1'b1; instr_ready = 1'b1;
    sync();
    cmd_valid = 1'b0; instr_ready = 1'b0;
    @(negedge clk);
    check("push_pop_count", 128'(count), 128'd3);
    sync();
    for (int i = 0; i < 3; i++) pop_one();
    @(negedge clk);
    check("drain_all", 128'(count), 128'd0);
    sync();

    // Flush together with a pop.
    for (int i = 1; i <= 3; i++) begin
      sb.push_back(mk(OP_FILL, 10'd200, 9'd100, 10'd7, 9'd5, 10'd44, 3'd0, 8'h00, 8'h00, 8'(i)));
      issue(OP_FILL, 28'(i));
    end
    opcode = OP_RESET; params = 28'h0; cmd_valid = 1'b1; instr_ready = 1'b1;
    sync();
    cmd_valid = 1'b0; instr_ready = 1'b0;
    sb.delete();
    @(negedge clk);
    check("flush_count", 128'(count), 128'd0);
    check("flush_valid", 128'(instr_valid), 128'd0);
    sync();
    sb.push_back(mk(OP_LINE, 10'd0, 9'd0, 10'd0, 9'd0, 10'd0, 3'd0, 8'h00, 8'h00, 8'h00));
    issue(OP_LINE, 28'h0);
    pop_one();

    // Illegal opcodes: sticky flag, no side effects, set beats clear.
    issue(OP_SET_XY1, {9'd0, 9'd3, 10'd9});
    sb.push_back(mk(OP_LINE, 10'd9, 9'd3, 10'd0, 9'd0, 10'd0, 3'd0, 8'h00, 8'h00, 8'h01));
    issue(OP_LINE, 28'd1);
    issue(4'b1010, 28'hFFFFFFF);
    @(negedge clk);
    check("illegal_set", 128'(illegal), 128'd1);
    check("illegal_count", 128'(count), 128'd1);
    sync();
    sb.push_back(mk(OP_LINE, 10'd9, 9'd3, 10'd0, 9'd0, 10'd0, 3'd0, 8'h00, 8'h00, 8'h02));
    issue(OP_LINE, 28'd2);
    pop_one();
    pop_one();
    clear_err = 1'b1; opcode = 4'b1111; cmd_valid = 1'b1;
    sync();
    clear_err = 1'b0; cmd_valid = 1'b0;
    @(negedge clk);
    check("set_beats_clear", 128'(illegal), 128'd1);
    sync();
    clear_err = 1'b1;
    sync();
    clear_err = 1'b0;
    @(negedge clk);
    check("clear_err", 128'(illegal), 128'd0);
    sync();

    // Mid-stream reset with entries queued and a pop requested.
    issue(4'b1001, 28'h0);
    for (int i = 1; i <= 2; i++) begin
      sb.push_back(mk(OP_FILL, 10'd9, 9'd3, 10'd0, 9'd0, 10'd0, 3'd0, 8'h00, 8'h00, 8'(i)));
      issue(OP_FILL, 28'(i));
    end
    @(negedge clk);
    check("pre_reset_count", 128'(count), 128'd2);
    check("pre_reset_illegal", 128'(illegal), 128'd1);
    sync();
    n_rst = 1'b0; instr_ready = 1'b1;
    @(negedge clk);
    check("in_reset_valid", 128'(instr_valid), 128'd0);
    sync();
    n_rst = 1'b1; instr_ready = 1'b0;
    sb.delete();
    @(negedge clk);
    check("post_reset_count", 128'(count), 128'd0);
    check("post_reset_valid", 128'(instr_valid), 128'd0);
    check("post_reset_illegal", 128'(illegal), 128'd0);
    sync();
    sb.push_back(mk(OP_LINE, 10'd0, 9'd0, 10'd0, 9'd0, 10'd0, 3'd0, 8'h00, 8'h00, 8'h07));
    issue(OP_LINE, 28'd7);
    pop_one();
    sync();
    check("scoreboard_empty", 128'(sb.size()), 128'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
